// File: rtl/dp3_div_ctrl.sv
// Restoring-division sequencer for the dp3 accumulator datapath.
// Drives dp3 load/mux/add-sub controls and counts the quotient; the remainder is left in dp3's A register.
module dp3_div_ctrl #(
   parameter int n = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [n-1:0] dIn,
   input  logic         Apos,
   input  logic         Aeq0,
   output logic         Aload,
   output logic         Sub,
   output logic [1:0]   Asel,
   output logic [n-1:0] dOut,
   output logic [n-1:0] quotient,
   output logic         busy,
   output logic         done,
   output logic         err
);

   typedef enum logic [2:0] {
      IDLE, LOAD, TEST0, SUB, TEST, RESTORE, DONE, CLEAR
   } state_t;

   state_t       state;
   logic [n-1:0] dreg;

   assign dOut = dreg;

   // Outputs are registered alongside the state, each set from the state being entered,
   // so they always match a decode of the current state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         Aload    <= 1'b0;
         Sub      <= 1'b0;
         Asel     <= 2'b00;
         dreg     <= '0;
         quotient <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         Aload <= 1'b0;
         Sub   <= 1'b0;
         Asel  <= 2'b00;
         done  <= 1'b0;
         busy  <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  dreg     <= dIn;
                  quotient <= '0;
                  err      <= 1'b0;
                  state    <= LOAD;
                  Aload    <= 1'b1;
                  Asel     <= 2'b01;
               end else begin
                  busy <= 1'b0;
               end
            end
            LOAD: state <= TEST0;
            TEST0: begin
               if (dreg == '0 || !Apos) begin
                  state <= CLEAR;
                  Aload <= 1'b1;
                  Asel  <= 2'b11;
                  err   <= 1'b1;
               end else if (Aeq0) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state <= SUB;
                  Aload <= 1'b1;
                  Sub   <= 1'b1;
               end
            end
            SUB: state <= TEST;
            TEST: begin
               // A went negative: this subtraction overshot, undo it and do not count it.
               if (!Apos) begin
                  state <= RESTORE;
                  Aload <= 1'b1;
               end else begin
                  quotient <= quotient + 1'b1;
                  if (Aeq0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= SUB;
                     Aload <= 1'b1;
                     Sub   <= 1'b1;
                  end
               end
            end
            RESTORE: begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            CLEAR: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dp3_div_ctrl.sv
// Bench for dp3_div_ctrl: a behavioural dp3 accumulator plus an arithmetic model of
// per-operation latency, quotient, remainder and error, checked every cycle.
module tb_dp3_div_ctrl;
   localparam int N = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] dIn = '0;
   logic [N-1:0] mInput = '0;
   logic         Apos, Aeq0, Aload, Sub, busy, done, err;
   logic [1:0]   Asel;
   logic [N-1:0] dOut, quotient;
   logic [N-1:0] A = '0;

   int checks = 0;
   int errors = 0;

   dp3_div_ctrl #(.n(N)) dut (
      .clock(clock), .reset(reset), .start(start), .dIn(dIn),
      .Apos(Apos), .Aeq0(Aeq0), .Aload(Aload), .Sub(Sub), .Asel(Asel),
      .dOut(dOut), .quotient(quotient), .busy(busy), .done(done), .err(err)
   );

   always #5 clock = ~clock;

   // dp3 datapath: A register fed by add/sub, mInput, dp1In or zero.
   always @(posedge clock) begin
      if (!reset) A <= '0;
      else if (Aload) begin
         case (Asel)
            2'b00:   A <= Sub ? A - dOut : A + dOut;
            2'b01:   A <= mInput;
            2'b10:   A <= dOut;
            default: A <= '0;
         endcase
      end
   end
   assign Apos = ~A[N-1];
   assign Aeq0 = (A == '0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic is_err(input logic [N-1:0] m, input logic [N-1:0] d);
      return (d == '0) || m[N-1];
   endfunction

   // Cycles from the accepted start edge to done (or to the CLEAR cycle on error).
   function automatic int op_len(input logic [N-1:0] m, input logic [N-1:0] d);
      int k;
      if (is_err(m, d)) return 2;
      k = int'(m) / int'(d);
      if (int'(m) % int'(d) == 0) return 2 + 2 * k;
      return 3 + 2 * (k + 1);
   endfunction

   function automatic int op_aloads(input logic [N-1:0] m, input logic [N-1:0] d);
      int k;
      if (is_err(m, d)) return 2;
      k = int'(m) / int'(d);
      if (int'(m) % int'(d) == 0) return 1 + k;
      return 1 + (k + 1) + 1;
   endfunction

   // Reference model: m_c counts edges since the accepted start edge.
   logic         m_act = 1'b0, m_errp = 1'b0, m_err = 1'b0, m_fin = 1'b0;
   int           m_c = 0, m_len = 0, m_aexp = 0, m_opid = 0;
   logic [N-1:0] m_q = '0, m_d = '0, m_qexp = '0, m_rem = '0;

   always @(posedge clock) begin
      if (!reset) begin
         m_act <= 1'b0; m_err <= 1'b0; m_q <= '0; m_d <= '0; m_fin <= 1'b0; m_c <= 0;
      end else if (m_act) begin
         m_c <= m_c + 1;
         if (m_c + 1 == m_len + 1) begin
            m_act <= 1'b0;
            m_fin <= 1'b1;
         end
         if (m_errp && m_c + 1 == 2) m_err <= 1'b1;
         if (!m_errp && m_c + 1 == m_len) m_q <= m_qexp;
      end else if (start) begin
         m_act  <= 1'b1;
         m_fin  <= 1'b0;
         m_c    <= 0;
         m_err  <= 1'b0;
         m_q    <= '0;
         m_d    <= dIn;
         m_errp <= is_err(mInput, dIn);
         m_len  <= op_len(mInput, dIn);
         m_aexp <= op_aloads(mInput, dIn);
         m_qexp <= is_err(mInput, dIn) ? '0 : mInput / dIn;
         m_rem  <= is_err(mInput, dIn) ? '0 : mInput % dIn;
         m_opid <= m_opid + 1;
      end
   end

   // Single compare process against the model.
   int acnt = 0;
   int chk_id = 0;
   always @(negedge clock) begin
      chk("busy", busy, m_act);
      chk("done", done, m_act && !m_errp && m_c == m_len);
      chk("err", err, m_err);
      chk("dOut", dOut, m_d);
      if (!m_act || (m_c == m_len && !m_errp)) chk("quotient", quotient, m_q);
      if (!m_act) begin
         chk("idle_Aload", Aload, 1'b0);
         chk("idle_Sub", Sub, 1'b0);
         chk("idle_Asel", Asel, 2'b00);
      end
      if (m_act && m_c == 0) acnt = 0;
      if (m_act && Aload) acnt++;
      if (!m_act && m_fin && m_opid != chk_id) begin
         chk("remainder", A, m_rem);
         chk("aload_count", acnt, m_aexp);
         chk_id = m_opid;
      end
   end

   task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] d, output int lat);
      @(posedge clock); #1;
      mInput = m; dIn = d; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      dIn = N'($urandom);
      lat = -1;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clock); #1;
         if (done || err) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) chk("timeout", 0, 1);
   endtask

   int lat;
   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_quot", quotient, 0);
      chk("rst_aload", Aload, 0);
      reset = 1'b1;

      run_op(8'd20, 8'd6, lat);
      chk("lat_20_6", lat, 11);
      chk("q_20_6", quotient, 3);
      chk("rem_20_6", A, 2);
      chk("err_20_6", err, 0);
      run_op(8'd18, 8'd6, lat);
      chk("lat_18_6", lat, 8);
      chk("q_18_6", quotient, 3);
      chk("rem_18_6", A, 0);
      run_op(8'd0, 8'd5, lat);
      chk("lat_0_5", lat, 2);
      chk("q_0_5", quotient, 0);
      run_op(8'd5, 8'd6, lat);
      chk("lat_5_6", lat, 5);
      chk("rem_5_6", A, 5);
      run_op(8'd9, 8'd0, lat);
      chk("err_d0", err, 1);
      chk("done_d0", done, 0);
      @(posedge clock); #1;
      chk("clr_d0", A, 0);
      run_op(8'd9, 8'd3, lat);
      chk("q_9_3", quotient, 3);
      chk("err_9_3", err, 0);
      run_op(8'h90, 8'd2, lat);
      chk("err_sign", err, 1);
      @(posedge clock); #1;
      chk("clr_sign", A, 0);

      // Mid-operation reset, with a start pulse while busy that must be ignored.
      @(posedge clock); #1;
      mInput = 8'd100; dIn = 8'd1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1; start = 1'b1; dIn = 8'd77;
      @(posedge clock); #1; start = 1'b0;
      repeat (37) @(posedge clock);
      #1; reset = 1'b0;
      @(posedge clock); #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_q", quotient, 0);
      chk("mid_rst_dout", dOut, 0);
      chk("mid_rst_aload", Aload, 0);
      reset = 1'b1;
      run_op(8'd100, 8'd1, lat);
      chk("lat_100_1", lat, 202);
      chk("q_100_1", quotient, 100);

      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] m, d;
         m = N'($urandom_range(0, 127));
         d = (i % 2 == 0) ? N'($urandom_range(1, 15)) : N'($urandom_range(1, 127));
         if ($urandom_range(0, 9) == 0) d = '0;
         if ($urandom_range(0, 9) == 0) m[N-1] = 1'b1;
         run_op(m, d, lat);
         chk("rand_lat", lat, op_len(m, d));
      end

      repeat (3) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
